// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared constants and types for the integer register file and its helpers.
// -----------------------------------------------------------------------------
package register_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // Register index as carried by the decode and write-back stages.
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One architectural register word.
    typedef logic [XLEN-1:0] xlen_t;

    // Write-back request as seen by the register file on one edge.
    typedef struct packed {
        logic      wren;
        reg_addr_t addr;
        xlen_t     data;
    } wb_req_t;

    // A write-back only changes state when enabled and not aimed at x0.
    function automatic logic wb_commits(input wb_req_t req);
        return req.wren && (req.addr != reg_addr_t'(0));
    endfunction

endpackage : register_file_pkg

// File: rtl/register_file_retire_counter.sv
// -----------------------------------------------------------------------------
// retire_counter
// Free-running event counter: adds one on each rising edge with i_inc high and
// wraps silently from all-ones to zero. Cleared asynchronously by i_reset low.
// -----------------------------------------------------------------------------
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: natural modular add gives the wrap without a compare.
    always_comb begin
        cnt_d = cnt_q;
        if (i_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous clear.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule : retire_counter

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 31 x 32-bit integer register file (x1..x31, x0 hard-wired to zero) with two
// combinational read ports, one write-back port and two retire counters
// (committed register writes, retired control-flow instructions).
//
// Build option: define REGFILE_BYPASS_EN to forward a committing write-back
// value to a same-cycle read of the same register. Without it, reads return
// the stored value and the new value is visible from the next cycle.
// -----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_rf_rd_addr,
    input  logic                  i_rf_rd_wren,
    input  logic [XLEN-1:0]       i_rf_rd_data,
    input  logic                  i_rf_ctrl,
    input  logic [REG_ADDR_W-1:0] i_rf_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rf_rs2_addr,
    output logic [XLEN-1:0]       o_rf_rs1_data,
    output logic [XLEN-1:0]       o_rf_rs2_data,
    output logic [CNT_W-1:0]      o_rf_wr_cnt,
    output logic [CNT_W-1:0]      o_rf_ctrl_cnt
);

    // x0 has no storage; only x1..x31 exist as flops.
    xlen_t   regs_q [1:NUM_REGS-1];
    xlen_t   regs_d [1:NUM_REGS-1];

    wb_req_t wb_req;
    logic    wb_commit;

    assign wb_req    = '{wren: i_rf_rd_wren, addr: i_rf_rd_addr, data: i_rf_rd_data};
    assign wb_commit = wb_commits(wb_req);

    // Write decode: only the addressed register takes the write-back data.
    // NOTE: regs_d is defaulted to regs_q before the conditional update so
    // every element is assigned on every path and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[wb_req.addr] = wb_req.data;
        end
    end

    // Register storage, cleared asynchronously while i_reset is low.
    // NOTE: this array is deliberately reset (all 31 entries), because
    // software-visible registers must read zero during and after reset;
    // a write presented during reset is lost since reset dominates the edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Stored value of a register, with x0 forced to zero.
    function automatic xlen_t stored_value(input reg_addr_t addr);
        xlen_t val;
        val = '0;
        if (addr != reg_addr_t'(0)) begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    // Value seen by a read port this cycle.
    function automatic xlen_t read_port(input reg_addr_t addr);
        xlen_t val;
        val = stored_value(addr);
`ifdef REGFILE_BYPASS_EN
        // Forward only a write that will actually commit, and never during
        // reset, where stored values are already zero.
        if (i_reset && wb_commit && (addr == wb_req.addr)) begin
            val = wb_req.data;
        end
`endif
        return val;
    endfunction

    // Combinational read ports; both use the same path so equal indices give
    // equal data.
    always_comb begin
        o_rf_rs1_data = read_port(i_rf_rs1_addr);
        o_rf_rs2_data = read_port(i_rf_rs2_addr);
    end

    // Counts register writes that actually commit (x0 writes excluded).
    retire_counter #(
        .CNT_W (CNT_W)
    ) u_wr_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (wb_commit),
        .o_cnt   (o_rf_wr_cnt)
    );

    // Counts retiring branch/JAL/JALR instructions, independent of write-back.
    retire_counter #(
        .CNT_W (CNT_W)
    ) u_ctrl_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (i_rf_ctrl),
        .o_cnt   (o_rf_ctrl_cnt)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed self-checking bench for register_file. A default-width instance and
// a CNT_W=4 instance share all stimulus. Expected same-cycle read results
// follow the REGFILE_BYPASS_EN build option.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [31:0] rd_data;
    logic        ctrl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wr_cnt;
    logic [31:0] ctrl_cnt;
    logic [31:0] rs1_data_w4;
    logic [31:0] rs2_data_w4;
    logic [3:0]  wr_cnt_w4;
    logic [3:0]  ctrl_cnt_w4;

    int errors = 0;
    int checks = 0;

    register_file dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rf_rd_addr  (rd_addr),
        .i_rf_rd_wren  (rd_wren),
        .i_rf_rd_data  (rd_data),
        .i_rf_ctrl     (ctrl),
        .i_rf_rs1_addr (rs1_addr),
        .i_rf_rs2_addr (rs2_addr),
        .o_rf_rs1_data (rs1_data),
        .o_rf_rs2_data (rs2_data),
        .o_rf_wr_cnt   (wr_cnt),
        .o_rf_ctrl_cnt (ctrl_cnt)
    );

    register_file #(.CNT_W(4)) dut_w4 (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rf_rd_addr  (rd_addr),
        .i_rf_rd_wren  (rd_wren),
        .i_rf_rd_data  (rd_data),
        .i_rf_ctrl     (ctrl),
        .i_rf_rs1_addr (rs1_addr),
        .i_rf_rs2_addr (rs2_addr),
        .o_rf_rs1_data (rs1_data_w4),
        .o_rf_rs2_data (rs2_data_w4),
        .o_rf_wr_cnt   (wr_cnt_w4),
        .o_rf_ctrl_cnt (ctrl_cnt_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one write-back/retire beat for a single edge.
    task automatic wb(input logic [4:0] addr, input logic [31:0] data,
                      input logic wren, input logic c);
        rd_addr = addr;
        rd_data = data;
        rd_wren = wren;
        ctrl    = c;
        tick();
        rd_wren = 1'b0;
        ctrl    = 1'b0;
    endtask

    // Read one register on both ports and compare both.
    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        rs1_addr = addr;
        rs2_addr = addr;
        #1;
        check({tag, "_rs1"}, rs1_data, exp);
        check({tag, "_rs2"}, rs2_data, exp);
    endtask

    // Clean reset pulse that leaves inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    logic [31:0] hz_exp;

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        rd_wren  = 1'b0;
        rd_data  = '0;
        ctrl     = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        #12;
        check("rst_wr_cnt", wr_cnt, 32'd0);
        check("rst_ctrl_cnt", ctrl_cnt, 32'd0);
        read_chk("rst_x0", 5'd0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write x5 then assert reset asynchronously (between edges).
        wb(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
        read_chk("x5_written", 5'd5, 32'hDEAD_BEEF);
        check("x5_wr_cnt", wr_cnt, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_x5_rs1", rs1_data, 32'h0);
        check("async_rst_x5_rs2", rs2_data, 32'h0);
        check("async_rst_wr_cnt", wr_cnt, 32'd0);
        check("async_rst_ctrl_cnt", ctrl_cnt, 32'd0);

        // Write presented while in reset: no bypass, no commit, no counting.
        rd_addr  = 5'd5;
        rd_data  = 32'hAAAA_5555;
        rd_wren  = 1'b1;
        ctrl     = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        #1;
        check("rst_no_bypass", rs1_data, 32'h0);
        tick();
        check("rst_write_dropped", rs1_data, 32'h0);
        check("rst_no_count_wr", wr_cnt, 32'd0);
        check("rst_no_count_ctrl", ctrl_cnt, 32'd0);
        rd_wren = 1'b0;
        ctrl    = 1'b0;
        rst_n   = 1'b1;
        tick();
        read_chk("post_rst_x5", 5'd5, 32'h0);

        // First edge after release: write resumes.
        wb(5'd9, 32'h0000_0099, 1'b1, 1'b0);
        read_chk("resume_x9", 5'd9, 32'h0000_0099);
        check("resume_wr_cnt", wr_cnt, 32'd1);

        // Write to x0 is discarded and not counted.
        wb(5'd0, 32'h1234_5678, 1'b1, 1'b0);
        read_chk("x0_write", 5'd0, 32'h0);
        check("x0_wr_cnt", wr_cnt, 32'd1);

        // Same-cycle hazard on x7.
        wb(5'd7, 32'h0000_0011, 1'b1, 1'b0);
        rd_addr  = 5'd7;
        rd_data  = 32'h0000_0022;
        rd_wren  = 1'b1;
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        hz_exp = 32'h0000_0022;
`else
        hz_exp = 32'h0000_0011;
`endif
        check("hazard_rs1", rs1_data, hz_exp);
        check("hazard_rs2", rs2_data, hz_exp);
        // wren=0 must never bypass.
        rd_wren = 1'b0;
        #1;
        check("no_wren_no_bypass", rs1_data, 32'h0000_0011);
        rd_wren = 1'b1;
        tick();
        rd_wren = 1'b0;
        read_chk("hazard_next", 5'd7, 32'h0000_0022);

        // Counters: 3 commits, 2 control cycles (one with wren=0).
        do_reset();
        wb(5'd1, 32'h1, 1'b1, 1'b1);
        wb(5'd2, 32'h2, 1'b1, 1'b0);
        wb(5'd2, 32'h3, 1'b0, 1'b1);
        wb(5'd3, 32'h4, 1'b1, 1'b0);
        check("cnt_wr", wr_cnt, 32'd3);
        check("cnt_ctrl", ctrl_cnt, 32'd2);
        check("cnt_w4_wr", {28'd0, wr_cnt_w4}, 32'd3);

        // Wrap: 17 commits + 17 control cycles on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wb(5'((i % 31) + 1), 32'(i), 1'b1, 1'b1);
        end
        check("wrap_wr_w4", {28'd0, wr_cnt_w4}, 32'd1);
        check("wrap_ctrl_w4", {28'd0, ctrl_cnt_w4}, 32'd1);
        check("wrap_wr_w32", wr_cnt, 32'd17);

        // Fill all registers and read back on both ports.
        do_reset();
        for (int n = 1; n < 32; n++) begin
            wb(5'(n), 32'(n) * 32'h0101_0101, 1'b1, 1'b0);
        end
        for (int n = 0; n < 32; n++) begin
            read_chk($sformatf("fill_x%0d", n), 5'(n), 32'(n) * 32'h0101_0101);
        end
        // Distinct indices on the two ports at once.
        rs1_addr = 5'd3;
        rs2_addr = 5'd30;
        #1;
        check("fill_split_rs1", rs1_data, 32'h0303_0303);
        check("fill_split_rs2", rs2_data, 32'h1E1E_1E1E);
        check("fill_wr_cnt", wr_cnt, 32'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_file
